mem_access_unit: RTL

Parametrised load/store access unit for the MEM stage of the rv32i pipeline. It replaces the purely combinational byte-access path with a sequenced unit.
- Accepts one load/store request from the pipeline and performs one or two aligned data-memory bus transactions.
- Handles wait states through a bus acknowledge.
- Returns aligned, sign- or zero-extended load data.
- Stalls the pipeline while busy.

---
 rtl/mem_access_unit.sv | 293 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Sequenced load/store unit for the MEM stage. Takes one request
//               from the pipeline, runs one (or, with the split option, two)
//               aligned data-bus transactions with ack-based wait states, and
//               returns a lane-aligned, sign/zero-extended load result.
//
// Ports
//   clk, rst_n                         clock / asynchronous active-low reset
//   req_valid, req_ready               request handshake (ready only in IDLE)
//   load, store, addr, func3, wdata    request fields
//   resp_valid, rdata, exc             one-cycle completion pulse and result
//   stall                              high whenever the unit is not IDLE
//   bus_req, bus_we, bus_addr,
//   bus_be, bus_wdata                  data-bus request (held until bus_ack)
//   bus_ack, bus_rdata                 data-bus completion and read word
//
// Build option
//   MISALIGN_SPLIT_EN  defined  : misaligned accesses crossing a bus word are
//                                 split into two transactions (ACC1, ACC2).
//                      undefined: misaligned accesses complete with exc=1 and
//                                 no bus activity.
//
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    localparam int BE_W  = XLEN / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              load,
    input  logic              store,
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        func3,
    input  logic [XLEN-1:0]   wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   rdata,
    output logic              exc,
    output logic              stall,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [BE_W-1:0]   bus_be,
    output logic [XLEN-1:0]   bus_wdata,
    input  logic              bus_ack,
    input  logic [XLEN-1:0]   bus_rdata
);

    localparam int OFF_W = $clog2(BE_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC1 = 2'd1,
        S_ACC2 = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_func3;
    logic [XLEN-1:0]   r_wdata;
    logic              r_is_load;
    logic              r_exc;
    logic [XLEN-1:0]   r_lo;
    logic [XLEN-1:0]   w_hi;

    // ------------------------------------------------------------------
    // Request decode (combinational on the pipeline inputs, used in IDLE)
    // ------------------------------------------------------------------
    logic w_accept;
    logic w_illegal;
    logic w_req_exc;

    assign w_accept = (r_state == S_IDLE) && req_valid && (load || store);

    always_comb begin
        w_illegal = (func3 == 3'b111) || (store && func3[2]) || (load && store);
        if (XLEN == 32 && (func3 == 3'b011 || func3 == 3'b110)) begin
            w_illegal = 1'b1;
        end
    end

`ifdef MISALIGN_SPLIT_EN
    assign w_req_exc = w_illegal;
`else
    // Without splitting, any offset not a multiple of the size is an error.
    logic [OFF_W-1:0] w_in_amask;
    logic             w_in_misal;

    always_comb begin
        case (func3[1:0])
            2'd0:    w_in_amask = '0;
            2'd1:    w_in_amask = OFF_W'(1);
            2'd2:    w_in_amask = OFF_W'(3);
            default: w_in_amask = OFF_W'(7);
        endcase
    end

    assign w_in_misal = (addr[OFF_W-1:0] & w_in_amask) != '0;
    assign w_req_exc  = w_illegal || w_in_misal;
`endif

    // ------------------------------------------------------------------
    // Access geometry from the latched request
    // ------------------------------------------------------------------
    logic [OFF_W-1:0]  w_off;
    logic [BE_W-1:0]   w_smask;
    logic [ADDR_W-1:0] w_base;
    logic [BE_W-1:0]   w_be_lo;
    logic [XLEN-1:0]   w_wd_lo;

    assign w_off  = r_addr[OFF_W-1:0];
    assign w_base = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    always_comb begin
        case (r_func3[1:0])
            2'd0:    w_smask = BE_W'(1);
            2'd1:    w_smask = BE_W'(3);
            2'd2:    w_smask = BE_W'(15);
            default: w_smask = '1;
        endcase
    end

    assign w_be_lo = w_smask << w_off;
    assign w_wd_lo = r_wdata << {w_off, 3'b000};

`ifdef MISALIGN_SPLIT_EN
    logic [XLEN-1:0] r_hi;
    logic [BE_W-1:0] w_be_hi;
    logic [XLEN-1:0] w_wd_hi;
    logic            w_cross;
    int              w_nbytes;

    // Second transaction carries whatever spilled past the first bus word.
    assign w_be_hi  = BE_W'(({{BE_W{1'b0}}, w_smask} << w_off) >> BE_W);
    assign w_wd_hi  = XLEN'(({{XLEN{1'b0}}, r_wdata} << {w_off, 3'b000}) >> XLEN);
    assign w_nbytes = 1 << r_func3[1:0];
    assign w_cross  = (int'(w_off) + w_nbytes) > BE_W;
    assign w_hi     = r_hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= '0;
        end else if (w_accept) begin
            r_hi <= '0;
        end else if (r_state == S_ACC2 && bus_ack) begin
            r_hi <= bus_rdata;
        end
    end
`else
    assign w_hi = '0;
`endif

    // ------------------------------------------------------------------
    // State register and request/data capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_func3   <= '0;
            r_wdata   <= '0;
            r_is_load <= 1'b0;
            r_exc     <= 1'b0;
            r_lo      <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr    <= addr;
                r_func3   <= func3;
                r_wdata   <= wdata;
                r_is_load <= load;
                r_exc     <= w_req_exc;
                r_lo      <= '0;
            end else if (r_state == S_ACC1 && bus_ack) begin
                r_lo <= bus_rdata;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_req_exc ? S_RESP : S_ACC1;
                end
            end
            S_ACC1: begin
                if (bus_ack) begin
`ifdef MISALIGN_SPLIT_EN
                    w_next = w_cross ? S_ACC2 : S_RESP;
`else
                    w_next = S_RESP;
`endif
                end
            end
`ifdef MISALIGN_SPLIT_EN
            S_ACC2: begin
                if (bus_ack) begin
                    w_next = S_RESP;
                end
            end
`endif
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Load data alignment and extension
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_sh;
    logic [XLEN-1:0] w_keep;
    logic            w_sign;
    logic            w_fill;
    logic [XLEN-1:0] w_ext;

    assign w_sh = XLEN'({w_hi, r_lo} >> {w_off, 3'b000});

    always_comb begin
        case (r_func3[1:0])
            2'd0: begin
                w_keep = XLEN'(8'hFF);
                w_sign = w_sh[7];
            end
            2'd1: begin
                w_keep = XLEN'(16'hFFFF);
                w_sign = w_sh[15];
            end
            2'd2: begin
                w_keep = XLEN'(32'hFFFF_FFFF);
                w_sign = w_sh[31];
            end
            default: begin
                w_keep = '1;
                w_sign = w_sh[XLEN-1];
            end
        endcase
    end

    assign w_fill = w_sign & ~r_func3[2];
    assign w_ext  = (w_sh & w_keep) | ({XLEN{w_fill}} & ~w_keep);

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        req_ready  = (r_state == S_IDLE);
        stall      = (r_state != S_IDLE);
        resp_valid = (r_state == S_RESP);
        exc        = (r_state == S_RESP) && r_exc;
        rdata      = '0;
        bus_req    = 1'b0;
        bus_we     = 1'b0;
        bus_addr   = '0;
        bus_be     = '0;
        bus_wdata  = '0;
        case (r_state)
            S_ACC1: begin
                bus_req   = 1'b1;
                bus_we    = ~r_is_load;
                bus_addr  = w_base;
                bus_be    = w_be_lo;
                bus_wdata = w_wd_lo;
            end
`ifdef MISALIGN_SPLIT_EN
            S_ACC2: begin
                bus_req   = 1'b1;
                bus_we    = ~r_is_load;
                bus_addr  = w_base + ADDR_W'(BE_W);
                bus_be    = w_be_hi;
                bus_wdata = w_wd_hi;
            end
`endif
            S_RESP: begin
                if (r_is_load && !r_exc) begin
                    rdata = w_ext;
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire
